// File: rtl/ecg_seq_pkg.sv
// ecg_seq_pkg: shared state encoding, ECG geometry and slot indexing for the ECG sequencer.
package ecg_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int ECGS_PER_COMP = 4;
    localparam int SAMPLES_PER_ECG = 4;
    function automatic int slot_idx(input logic [1:0] comp, input logic [1:0] ecg);
        return int'(comp) * ECGS_PER_COMP + int'(ecg);
    endfunction
endpackage

// File: rtl/ecg_sequencer_if.sv
// ecg_sequencer_if: residual-block handshake and ECG slot bus between quantizer, sequencer and encoder.
interface ecg_sequencer_if #(parameter int DW = 10, parameter int NUM_COMP = 3);
    logic blk_valid;
    logic blk_ready;
    logic [NUM_COMP*16*DW-1:0] blk_residuals;
    logic [NUM_COMP-1:0] comp_skip_mask;
    logic [1:0] sub_sample_info_i;
    logic [4*DW-1:0] enc_sample;
    logic [1:0] enc_ecgidx;
    logic [1:0] enc_comp_idx;
    logic [1:0] enc_sub_sample;
    logic enc_comp_skip;
    logic enc_uflow_prev;
    logic [7:0] enc_stuff_bits;
    logic enc_issue;
    logic enc_valid_in;
    logic [6:0] enc_size_in;
    modport master (
        input blk_valid, blk_residuals, comp_skip_mask, sub_sample_info_i, enc_valid_in, enc_size_in,
        output blk_ready, enc_sample, enc_ecgidx, enc_comp_idx, enc_sub_sample, enc_comp_skip,
        enc_uflow_prev, enc_stuff_bits, enc_issue
    );
    modport slave (
        output blk_valid, blk_residuals, comp_skip_mask, sub_sample_info_i, enc_valid_in, enc_size_in,
        input blk_ready, enc_sample, enc_ecgidx, enc_comp_idx, enc_sub_sample, enc_comp_skip,
        enc_uflow_prev, enc_stuff_bits, enc_issue
    );
endinterface

// File: rtl/ecg_fullness_tracker.sv
// ecg_fullness_tracker: rate-buffer fullness model, adds encoded ECG sizes and drains one block per done.
module ecg_fullness_tracker #(
    parameter int FW = 16,
    parameter int BITS_PER_BLOCK = 96
) (
    input logic clk,
    input logic rst,
    input logic add_en,
    input logic [6:0] add,
    input logic sub_en,
    output logic [FW-1:0] fullness,
    output logic ovf_sticky
);
    logic [FW:0] tot, net;
    // add and drain are netted before clamping so a same-cycle pair never floors early
    always_comb begin
        tot = {1'b0, fullness} + (add_en ? (FW+1)'(add) : '0);
        net = !sub_en ? tot : tot < (FW+1)'(BITS_PER_BLOCK) ? '0 : tot - (FW+1)'(BITS_PER_BLOCK);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fullness <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            fullness <= net[FW] ? '1 : net[FW-1:0];
            ovf_sticky <= ovf_sticky | net[FW];
        end
    end
endmodule

// File: rtl/ecg_sequencer.sv
// ecg_sequencer: issues one BP residual block to the entropy encoder as ECG slots and tracks fullness.
// Define ECG_SEQ_STATS_EN to add stat_blocks / stat_stuff counters.
module ecg_sequencer
    import ecg_seq_pkg::*;
#(
    parameter int DW = 10,
    parameter int NUM_COMP = 3,
    parameter int FW = 16,
    parameter int BITS_PER_BLOCK = 96,
    parameter int UFLOW_THRESH = 96
) (
    input logic clk,
    input logic rst,
    ecg_sequencer_if.master bus,
    output logic [FW-1:0] fullness,
    output logic ovf_sticky,
    output logic blk_done
`ifdef ECG_SEQ_STATS_EN
    ,
    output logic [31:0] stat_blocks,
    output logic [31:0] stat_stuff
`endif
);
    state_t state, state_nx;
    logic [NUM_COMP*16*DW-1:0] res;
    logic [NUM_COMP-1:0] mask;
    logic [1:0] comp, ecg;
    logic [4:0] iss_cnt, ret_cnt;
    logic uflow;
    logic [7:0] stuff;
    logic [FW:0] gap;
    logic accept, issuing, skip, last;
    assign accept = state == IDLE && bus.blk_valid;
    assign issuing = state == ISSUE;
    assign skip = mask[comp];
    assign last = comp == 2'(NUM_COMP - 1) && (skip || ecg == 2'(ECGS_PER_COMP - 1));
    assign gap = (FW+1)'(UFLOW_THRESH) - {1'b0, fullness};
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (bus.blk_valid ? ISSUE : IDLE)
                 : state == ISSUE ? (last ? DRAIN : ISSUE)
                 : (ret_cnt == iss_cnt ? IDLE : DRAIN);
    end
    always_comb begin
        bus.blk_ready = state == IDLE;
        bus.enc_issue = issuing;
        bus.enc_comp_idx = issuing ? comp : 2'd0;
        bus.enc_ecgidx = issuing && !skip ? ecg : 2'd0;
        bus.enc_comp_skip = issuing && skip;
        bus.enc_sample = issuing && !skip ? res[slot_idx(comp, ecg) * SAMPLES_PER_ECG * DW +: SAMPLES_PER_ECG * DW] : '0;
        bus.enc_uflow_prev = issuing && last && uflow;
        bus.enc_stuff_bits = issuing && last && uflow ? stuff : 8'd0;
        blk_done = state == DRAIN && ret_cnt == iss_cnt;
    end
    // returns are counted from the first slot on, so fast encoders may finish before DRAIN is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            mask <= '0;
            comp <= 2'd0;
            ecg <= 2'd0;
            iss_cnt <= 5'd0;
            ret_cnt <= 5'd0;
            uflow <= 1'b0;
            stuff <= 8'd0;
            bus.enc_sub_sample <= 2'd0;
        end else begin
            bus.enc_sub_sample <= bus.sub_sample_info_i;
            if (accept) begin
                res <= bus.blk_residuals;
                mask <= bus.comp_skip_mask;
                comp <= 2'd0;
                ecg <= 2'd0;
                iss_cnt <= 5'd0;
                ret_cnt <= 5'd0;
                uflow <= fullness < FW'(UFLOW_THRESH);
                stuff <= gap > (FW+1)'(255) ? 8'hff : gap[7:0];
            end
            if (issuing) begin
                iss_cnt <= iss_cnt + 5'd1;
                ecg <= skip || ecg == 2'(ECGS_PER_COMP - 1) ? 2'd0 : ecg + 2'd1;
                comp <= skip || ecg == 2'(ECGS_PER_COMP - 1) ? comp + 2'd1 : comp;
            end
            if (bus.enc_valid_in && state != IDLE) ret_cnt <= ret_cnt + 5'd1;
        end
    end
    ecg_fullness_tracker #(.FW(FW), .BITS_PER_BLOCK(BITS_PER_BLOCK)) tracker (
        .clk(clk),
        .rst(rst),
        .add_en(bus.enc_valid_in),
        .add(bus.enc_size_in),
        .sub_en(blk_done),
        .fullness(fullness),
        .ovf_sticky(ovf_sticky)
    );
`ifdef ECG_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_blocks <= 32'd0;
            stat_stuff <= 32'd0;
        end else begin
            stat_blocks <= stat_blocks + 32'(blk_done);
            stat_stuff <= stat_stuff + 32'(bus.enc_stuff_bits);
        end
    end
`endif
endmodule

// File: tb/tb_ecg_sequencer.sv
// tb_ecg_sequencer: randomized block sequencing against a slot-list and fullness reference model.
module tb_ecg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] fullness;
    logic ovf_sticky, blk_done;
`ifdef ECG_SEQ_STATS_EN
    logic [31:0] stat_blocks, stat_stuff;
`endif
    int checks = 0;
    int errors = 0;
    int f = 0;
    bit ovf = 0;
    ecg_sequencer_if #(.DW(10), .NUM_COMP(3)) bus ();
    ecg_sequencer #(.DW(10), .NUM_COMP(3), .FW(16), .BITS_PER_BLOCK(96), .UFLOW_THRESH(96)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fullness(fullness),
        .ovf_sticky(ovf_sticky),
        .blk_done(blk_done)
`ifdef ECG_SEQ_STATS_EN
        ,
        .stat_blocks(stat_blocks),
        .stat_stuff(stat_stuff)
`endif
    );
    always #5 clk = ~clk;
    // one clock: reference fullness follows the driven returns and the block-done the model expects
    task automatic tick(input bit done);
        @(posedge clk);
        if (rst) begin
            f = 0;
            ovf = 0;
        end else begin
            f += (bus.enc_valid_in ? int'(bus.enc_size_in) : 0) - (done ? 96 : 0);
            if (f < 0) f = 0;
            if (f > 65535) begin
                f = 65535;
                ovf = 1;
            end
        end
        @(negedge clk);
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.blk_valid = 1'b0;
        bus.blk_residuals = '0;
        bus.comp_skip_mask = 3'd0;
        bus.sub_sample_info_i = 2'd0;
        bus.enc_valid_in = 1'b0;
        bus.enc_size_in = 7'd0;
        repeat (2) tick(0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.blk_ready !== 1'b1 || fullness !== 16'd0 || bus.enc_issue !== 1'b0 || blk_done !== 1'b0
                || ovf_sticky !== 1'b0 || bus.enc_uflow_prev !== 1'b0 || bus.enc_stuff_bits !== 8'd0
                || bus.enc_sample !== 40'd0 || bus.enc_comp_skip !== 1'b0 || bus.enc_sub_sample !== 2'd0) begin
                errors++;
                $display("FAIL reset cyc %0d: ready=%b full=%0d issue=%b done=%b ovf=%b uf=%b stuff=%0d, required 1 0 0 0 0 0 0",
                         i, bus.blk_ready, fullness, bus.enc_issue, blk_done, ovf_sticky, bus.enc_uflow_prev, bus.enc_stuff_bits);
            end
            tick(0);
        end
    endtask
    // one block: expected slots from the mask, encoder returns each slot after a random latency
    task automatic run_block(input logic [2:0] m, input bit fixed, input int max_sz);
        int sc[$], se[$], rt[$], rs[$];
        logic [479:0] r;
        logic [39:0] es;
        logic [1:0] sub_prev;
        int n, done_k, last, t, st;
        bit uf, lastslot;
        for (int c = 0; c < 3; c++)
            for (int e = 0; e < (m[c] ? 1 : 4); e++) begin
                sc.push_back(c);
                se.push_back(m[c] ? -1 : e);
            end
        n = sc.size();
        uf = f < 96;
        st = uf ? ((96 - f) > 255 ? 255 : 96 - f) : 0;
        for (int i = 0; i < 15; i++) r[i*32 +: 32] = $urandom;
        last = -1;
        for (int i = 0; i < n; i++) begin
            t = i + (fixed ? 0 : int'($urandom_range(0, 3)));
            if (t <= last) t = last + 1;
            rt.push_back(t);
            rs.push_back(fixed ? 10 : int'($urandom_range(0, max_sz)));
            last = t;
        end
        done_k = last + 1;
        checks++;
        if (bus.blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready before block: got %b, required 1", bus.blk_ready);
        end
        bus.blk_residuals = r;
        bus.comp_skip_mask = m;
        bus.blk_valid = 1'b1;
        bus.enc_valid_in = 1'b0;
        sub_prev = bus.sub_sample_info_i;
        tick(0);
        bus.blk_valid = 1'b0;
        bus.blk_residuals = ~r;
        bus.comp_skip_mask = ~m;
        for (int k = 0; k <= done_k; k++) begin
            if (k < n) begin
                es = se[k] < 0 ? 40'd0 : r[(sc[k]*16 + se[k]*4)*10 +: 40];
                lastslot = k == n - 1;
                checks++;
                if (bus.enc_issue !== 1'b1 || bus.enc_comp_idx !== 2'(sc[k]) || bus.enc_ecgidx !== (se[k] < 0 ? 2'd0 : 2'(se[k]))
                    || bus.enc_comp_skip !== (se[k] < 0) || bus.enc_sample !== es) begin
                    errors++;
                    $display("FAIL slot %0d mask %b: issue=%b c=%0d e=%0d skip=%b smp=%h, required 1 %0d %0d %b %h",
                             k, m, bus.enc_issue, bus.enc_comp_idx, bus.enc_ecgidx, bus.enc_comp_skip, bus.enc_sample,
                             sc[k], se[k] < 0 ? 0 : se[k], se[k] < 0, es);
                end
                checks++;
                if (bus.enc_uflow_prev !== (uf && lastslot) || bus.enc_stuff_bits !== ((uf && lastslot) ? 8'(st) : 8'd0)) begin
                    errors++;
                    $display("FAIL uflow slot %0d: uf=%b stuff=%0d, required %b %0d",
                             k, bus.enc_uflow_prev, bus.enc_stuff_bits, uf && lastslot, (uf && lastslot) ? st : 0);
                end
            end else begin
                checks++;
                if (bus.enc_issue !== 1'b0) begin
                    errors++;
                    $display("FAIL drain issue cyc %0d: got %b, required 0", k, bus.enc_issue);
                end
            end
            checks++;
            if (blk_done !== (k == done_k)) begin
                errors++;
                $display("FAIL blk_done cyc %0d: got %b, required %b", k, blk_done, k == done_k);
            end
            checks++;
            if (fullness !== 16'(f) || ovf_sticky !== ovf) begin
                errors++;
                $display("FAIL fullness cyc %0d: got %0d ovf %b, required %0d ovf %b", k, fullness, ovf_sticky, f, ovf);
            end
            checks++;
            if (bus.enc_sub_sample !== sub_prev) begin
                errors++;
                $display("FAIL sub_sample cyc %0d: got %0d, required %0d", k, bus.enc_sub_sample, sub_prev);
            end
            sub_prev = 2'($urandom_range(0, 3));
            bus.sub_sample_info_i = sub_prev;
            if (rt.size() > 0 && rt[0] == k) begin
                bus.enc_valid_in = 1'b1;
                bus.enc_size_in = 7'(rs[0]);
                void'(rt.pop_front());
                void'(rs.pop_front());
            end else begin
                bus.enc_valid_in = 1'b0;
                bus.enc_size_in = 7'($urandom);
            end
            tick(k == done_k);
        end
        bus.enc_valid_in = 1'b0;
        checks++;
        if (bus.blk_ready !== 1'b1 || blk_done !== 1'b0 || bus.enc_issue !== 1'b0) begin
            errors++;
            $display("FAIL after block: ready=%b done=%b issue=%b, required 1 0 0", bus.blk_ready, blk_done, bus.enc_issue);
        end
    endtask
    task automatic test_full_block;
        run_block(3'b000, 1, 0);
        checks++;
        if (fullness !== 16'd24) begin
            errors++;
            $display("FAIL first block fullness: got %0d, required 24", fullness);
        end
        run_block(3'b000, 1, 0);
        checks++;
        if (fullness !== 16'd48) begin
            errors++;
            $display("FAIL second block fullness: got %0d, required 48", fullness);
        end
    endtask
    task automatic test_skip;
        run_block(3'b010, 1, 0);
        checks++;
        if (fullness !== 16'd42) begin
            errors++;
            $display("FAIL skip block fullness: got %0d, required 42", fullness);
        end
        run_block(3'b101, 0, 20);
        run_block(3'b111, 0, 20);
    endtask
    task automatic test_back_to_back;
        for (int i = 0; i < 25; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                bus.enc_valid_in = 1'($urandom);
                bus.enc_size_in = 7'($urandom_range(0, 40));
                tick(0);
                checks++;
                if (fullness !== 16'(f) || bus.blk_ready !== 1'b1 || blk_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle gap: full=%0d ready=%b done=%b, required %0d 1 0", fullness, bus.blk_ready, blk_done, f);
                end
            end
            bus.enc_valid_in = 1'b0;
            run_block(3'($urandom), 0, (i % 2) ? 12 : 40);
        end
    endtask
    task automatic test_rst_mid;
        bus.comp_skip_mask = 3'd0;
        bus.blk_residuals = '1;
        bus.blk_valid = 1'b1;
        tick(0);
        bus.blk_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.enc_valid_in = 1'b1;
            bus.enc_size_in = 7'd10;
            tick(0);
        end
        checks++;
        if (bus.enc_issue !== 1'b1 || bus.enc_comp_idx !== 2'd1 || bus.enc_ecgidx !== 2'd0) begin
            errors++;
            $display("FAIL fifth slot: issue=%b c=%0d e=%0d, required 1 1 0", bus.enc_issue, bus.enc_comp_idx, bus.enc_ecgidx);
        end
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        bus.enc_valid_in = 1'b0;
        checks++;
        if (bus.blk_ready !== 1'b1 || bus.enc_issue !== 1'b0 || blk_done !== 1'b0 || fullness !== 16'd0) begin
            errors++;
            $display("FAIL after mid rst: ready=%b issue=%b done=%b full=%0d, required 1 0 0 0",
                     bus.blk_ready, bus.enc_issue, blk_done, fullness);
        end
        for (int i = 0; i < 20; i++) begin
            tick(0);
            checks++;
            if (blk_done !== 1'b0 || bus.enc_issue !== 1'b0) begin
                errors++;
                $display("FAIL abandoned block cyc %0d: done=%b issue=%b, required 0 0", i, blk_done, bus.enc_issue);
            end
        end
        run_block(3'b000, 0, 30);
    endtask
    task automatic test_overflow;
        bus.enc_valid_in = 1'b1;
        bus.enc_size_in = 7'd127;
        repeat (600) tick(0);
        bus.enc_valid_in = 1'b0;
        checks++;
        if (fullness !== 16'hffff || ovf_sticky !== 1'b1 || fullness !== 16'(f) || bus.enc_issue !== 1'b0) begin
            errors++;
            $display("FAIL saturate: full=%0d ovf=%b issue=%b, required 65535 1 0", fullness, ovf_sticky, bus.enc_issue);
        end
        run_block(3'b000, 0, 40);
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf sticky after drain: got %b, required 1", ovf_sticky);
        end
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0 || fullness !== 16'd0) begin
            errors++;
            $display("FAIL ovf clear by rst: ovf=%b full=%0d, required 0 0", ovf_sticky, fullness);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        test_reset;
        test_full_block;
        test_skip;
        test_back_to_back;
        test_rst_mid;
        test_overflow;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
